// File: rtl/any1_ifq_pkg.sv
// Shared types and constants for the ANY-1 instruction fetch queue.
package any1_ifq_pkg;

    typedef enum logic [1:0] {
        IFQ_IDLE,
        IFQ_FETCH,
        IFQ_DRAIN
    } ifq_state_t;

    // Logical layout of one queue entry; pc is sized for the widest supported address.
    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] insn;
        logic        fault;
    } ifq_entry_t;

    localparam logic [7:0] IFQ_SEL_ALL = 8'hFF;

endpackage

// File: rtl/any1_ifq_fifo.sv
// Register FIFO holding fetched {pc, insn[, fault]} entries; clear overrides push/pop.
module any1_ifq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 96
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop) rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/any1_ifetch_queue.sv
// ANY-1 fetch stage: one-outstanding-cycle bus FSM feeding a small queue for decode.
// Optional bus timeout with fault entries is enabled by defining ANY1_IFQ_BUSTMO_EN.
module any1_ifetch_queue
    import any1_ifq_pkg::*;
#(
    parameter int             AWID       = 32,
    parameter logic [AWID-1:0] RSTPC     = 'hFFFC0100,
    parameter int             DEPTH      = 4,
    parameter int             TMO_CYCLES = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            redirect_i,
    input  logic [AWID-1:0] redirect_pc_i,
    input  logic            dec_rdy_i,
    output logic            dir_v_o,
    output logic [63:0]     dir_o,
    output logic [AWID-1:0] ipc_o,
    output logic            fault_o,
    output logic            vpa_o,
    output logic            cyc_o,
    output logic            stb_o,
    output logic            we_o,
    output logic [7:0]      sel_o,
    output logic [AWID-1:0] adr_o,
    input  logic            ack_i,
    input  logic [63:0]     dat_i
);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
    localparam logic [AWID-1:0] PC_LO   = AWID'(7);
    localparam logic [AWID-1:0] PC_STEP = AWID'(8);
`ifdef ANY1_IFQ_BUSTMO_EN
    localparam int TW = ($clog2(TMO_CYCLES+1) > 8) ? $clog2(TMO_CYCLES+1) : 8;
    localparam int EW = AWID + 65;
`else
    localparam int EW = AWID + 64;
`endif

    ifq_state_t      state, state_nxt;
    logic [AWID-1:0] fetch_pc, fetch_pc_nxt;
    logic [AWID-1:0] adr_nxt;
    logic            bus_act, bus_nxt;
    logic            push, pop;
    logic [EW-1:0]   push_data, head;
    logic [CW-1:0]   count;

`ifdef ANY1_IFQ_BUSTMO_EN
    logic [TW-1:0]   tmo_cnt;
    logic            tmo_load, tmo_hit;
    logic            stalled, stall_set;

    assign tmo_hit = (tmo_cnt == '0);
`endif

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        adr_nxt      = adr_o;
        bus_nxt      = bus_act;
        push         = 1'b0;
`ifdef ANY1_IFQ_BUSTMO_EN
        tmo_load     = 1'b0;
        stall_set    = 1'b0;
        push_data    = {1'b0, fetch_pc, dat_i};
`else
        push_data    = {fetch_pc, dat_i};
`endif
        case (state)
            IFQ_IDLE: begin
`ifdef ANY1_IFQ_BUSTMO_EN
                if (!redirect_i && count < DEPTH_C && !stalled) begin
                    tmo_load = 1'b1;
`else
                if (!redirect_i && count < DEPTH_C) begin
`endif
                    bus_nxt   = 1'b1;
                    adr_nxt   = fetch_pc;
                    state_nxt = IFQ_FETCH;
                end
            end
            IFQ_FETCH: begin
                if (ack_i) begin
                    bus_nxt   = 1'b0;
                    state_nxt = IFQ_IDLE;
                    if (!redirect_i) begin
                        push         = 1'b1;
                        fetch_pc_nxt = fetch_pc + PC_STEP;
                    end
`ifdef ANY1_IFQ_BUSTMO_EN
                end else if (tmo_hit) begin
                    // Abandoned fetch leaves a fault marker and parks until redirected.
                    bus_nxt   = 1'b0;
                    state_nxt = IFQ_IDLE;
                    if (!redirect_i) begin
                        push      = 1'b1;
                        stall_set = 1'b1;
                        push_data = {1'b1, fetch_pc, 64'd0};
                    end
`endif
                end else if (redirect_i) begin
                    state_nxt = IFQ_DRAIN;
                end
            end
            IFQ_DRAIN: begin
`ifdef ANY1_IFQ_BUSTMO_EN
                if (ack_i || tmo_hit) begin
`else
                if (ack_i) begin
`endif
                    bus_nxt   = 1'b0;
                    state_nxt = IFQ_IDLE;
                end
            end
            default: begin
                bus_nxt   = 1'b0;
                state_nxt = IFQ_IDLE;
            end
        endcase
        if (redirect_i) fetch_pc_nxt = redirect_pc_i & ~PC_LO;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IFQ_IDLE;
            fetch_pc <= RSTPC;
            adr_o    <= '0;
            bus_act  <= 1'b0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            adr_o    <= adr_nxt;
            bus_act  <= bus_nxt;
        end
    end

`ifdef ANY1_IFQ_BUSTMO_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_cnt <= '0;
            stalled <= 1'b0;
        end else begin
            if (tmo_load)
                tmo_cnt <= TW'(TMO_CYCLES - 1);
            else if (state != IFQ_IDLE && !tmo_hit)
                tmo_cnt <= tmo_cnt - TW'(1);
            if (redirect_i)
                stalled <= 1'b0;
            else if (stall_set)
                stalled <= 1'b1;
        end
    end
`endif

    assign pop = dir_v_o && dec_rdy_i && !redirect_i;

    any1_ifq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .clear (redirect_i),
        .push  (push),
        .pop   (pop),
        .din   (push_data),
        .dout  (head),
        .count (count)
    );

    assign dir_v_o = (count != '0);
    assign dir_o   = head[63:0];
    assign ipc_o   = head[AWID+63:64];
`ifdef ANY1_IFQ_BUSTMO_EN
    assign fault_o = head[EW-1];
`else
    assign fault_o = 1'b0;
`endif
    assign vpa_o = bus_act;
    assign cyc_o = bus_act;
    assign stb_o = bus_act;
    assign we_o  = 1'b0;
    assign sel_o = bus_act ? IFQ_SEL_ALL : 8'h00;

endmodule

// File: tb/tb_any1_ifetch_queue.sv
// Directed bench for any1_ifetch_queue; timeout checks run only with ANY1_IFQ_BUSTMO_EN.
module tb_any1_ifetch_queue;
`ifdef ANY1_IFQ_BUSTMO_EN
    localparam int TB_TMO = 4;
`else
    localparam int TB_TMO = 255;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        dec_rdy_i;
    logic        dir_v_o;
    logic [63:0] dir_o;
    logic [31:0] ipc_o;
    logic        fault_o;
    logic        vpa_o, cyc_o, stb_o, we_o;
    logic [7:0]  sel_o;
    logic [31:0] adr_o;
    logic        ack_i;
    logic [63:0] dat_i;

    int n_cmp = 0;
    int n_err = 0;

    any1_ifetch_queue #(
        .AWID       (32),
        .RSTPC      (32'hFFFC0100),
        .DEPTH      (4),
        .TMO_CYCLES (TB_TMO)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .dec_rdy_i     (dec_rdy_i),
        .dir_v_o       (dir_v_o),
        .dir_o         (dir_o),
        .ipc_o         (ipc_o),
        .fault_o       (fault_o),
        .vpa_o         (vpa_o),
        .cyc_o         (cyc_o),
        .stb_o         (stb_o),
        .we_o          (we_o),
        .sel_o         (sel_o),
        .adr_o         (adr_o),
        .ack_i         (ack_i),
        .dat_i         (dat_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] dat_of(input logic [31:0] a);
        return {~a, a};
    endfunction

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_cyc();
        int n = 0;
        while (!cyc_o && n < 50) begin
            tick();
            n++;
        end
        if (!cyc_o) chk("cyc_wait_timeout", 64'(cyc_o), 64'd1);
    endtask

    task automatic do_reset();
        rst_i         = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        dec_rdy_i     = 1'b0;
        ack_i         = 1'b0;
        dat_i         = '0;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic ack_now(input logic [63:0] d);
        ack_i = 1'b1;
        dat_i = d;
        tick();
        ack_i = 1'b0;
        dat_i = '0;
    endtask

    int cyc_seen;

    initial begin
        // Reset values
        do_reset();
        rst_i = 1'b1;
        tick();
        chk("rst_cyc", 64'(cyc_o), 64'd0);
        chk("rst_adr", 64'(adr_o), 64'd0);
        chk("rst_sel", 64'(sel_o), 64'd0);
        chk("rst_dirv", 64'(dir_v_o), 64'd0);
        chk("rst_fault", 64'(fault_o), 64'd0);
        chk("rst_we", 64'(we_o), 64'd0);
        rst_i = 1'b0;

        // Sequential fetch, one wait state, decode always ready
        dec_rdy_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            logic [31:0] a;
            a = 32'hFFFC0100 + 32'(8 * i);
            wait_cyc();
            chk("seq_adr", 64'(adr_o), 64'(a));
            chk("seq_sel", 64'(sel_o), 64'hFF);
            tick();
            chk("seq_hold_adr", 64'(adr_o), 64'(a));
            ack_now(dat_of(a));
            chk("seq_cyc_drop", 64'(cyc_o), 64'd0);
            chk("seq_dirv", 64'(dir_v_o), 64'd1);
            chk("seq_ipc", 64'(ipc_o), 64'(a));
            chk("seq_dir", dir_o, dat_of(a));
        end

        // Fill to DEPTH with decode stalled, then release one entry
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wait_cyc();
            chk("fill_adr", 64'(adr_o), 64'(32'hFFFC0100 + 32'(8 * i)));
            ack_now(dat_of(32'hFFFC0100 + 32'(8 * i)));
        end
        cyc_seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (cyc_o) cyc_seen++;
        end
        chk("full_no_fetch", 64'(cyc_seen), 64'd0);
        chk("full_ipc", 64'(ipc_o), 64'hFFFC0100);
        chk("full_dir", dir_o, dat_of(32'hFFFC0100));
        dec_rdy_i = 1'b1;
        tick();
        dec_rdy_i = 1'b0;
        chk("pop_ipc", 64'(ipc_o), 64'hFFFC0108);
        tick();
        chk("refill_cyc", 64'(cyc_o), 64'd1);
        chk("refill_adr", 64'(adr_o), 64'hFFFC0120);
        ack_now(dat_of(32'hFFFC0120));
        cyc_seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (cyc_o) cyc_seen++;
        end
        chk("refill_once", 64'(cyc_seen), 64'd0);
        chk("hold_ipc", 64'(ipc_o), 64'hFFFC0108);

        // Redirect while a fetch is pending: drain, then fetch target
        do_reset();
        wait_cyc();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h00001004;
        tick();
        redirect_i = 1'b0;
        chk("drain_hold_cyc", 64'(cyc_o), 64'd1);
        chk("drain_hold_adr", 64'(adr_o), 64'hFFFC0100);
        tick();
        tick();
        chk("drain_dirv", 64'(dir_v_o), 64'd0);
        ack_now(64'hDEAD_BEEF_DEAD_BEEF);
        chk("drain_discard", 64'(dir_v_o), 64'd0);
        chk("drain_cyc_drop", 64'(cyc_o), 64'd0);
        tick();
        chk("redir_adr", 64'(adr_o), 64'h00001000);
        ack_now(dat_of(32'h00001000));
        chk("redir_ipc", 64'(ipc_o), 64'h00001000);
        chk("redir_dir", dir_o, dat_of(32'h00001000));

        // Redirect coinciding with ack, two entries queued
        wait_cyc();
        chk("q2_adr", 64'(adr_o), 64'h00001008);
        ack_now(dat_of(32'h00001008));
        wait_cyc();
        chk("q2_adr3", 64'(adr_o), 64'h00001010);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h00002000;
        ack_now(64'h1111_2222_3333_4444);
        redirect_i = 1'b0;
        chk("same_dirv", 64'(dir_v_o), 64'd0);
        chk("same_cyc", 64'(cyc_o), 64'd0);
        tick();
        chk("same_adr", 64'(adr_o), 64'h00002000);
        ack_now(dat_of(32'h00002000));
        chk("same_ipc", 64'(ipc_o), 64'h00002000);

        // Redirect from IDLE to the top of the address space, then wrap
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFFFFFB;
        tick();
        redirect_i = 1'b0;
        chk("idle_redir_cyc", 64'(cyc_o), 64'd0);
        chk("idle_redir_dirv", 64'(dir_v_o), 64'd0);
        tick();
        chk("wrap_adr0", 64'(adr_o), 64'hFFFFFFF8);
        ack_now(dat_of(32'hFFFFFFF8));
        chk("wrap_ipc", 64'(ipc_o), 64'hFFFFFFF8);
        tick();
        chk("wrap_adr1", 64'(adr_o), 64'h00000000);

`ifdef ANY1_IFQ_BUSTMO_EN
        // Bus timeout: fault entry, then stall until redirected
        do_reset();
        wait_cyc();
        cyc_seen = 0;
        for (int i = 0; i < 20 && cyc_o; i++) begin
            cyc_seen++;
            tick();
        end
        chk("tmo_len", 64'(cyc_seen), 64'd4);
        chk("tmo_fault", 64'(fault_o), 64'd1);
        chk("tmo_dirv", 64'(dir_v_o), 64'd1);
        chk("tmo_ipc", 64'(ipc_o), 64'hFFFC0100);
        chk("tmo_dir", dir_o, 64'd0);
        cyc_seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (cyc_o) cyc_seen++;
        end
        chk("tmo_stall", 64'(cyc_seen), 64'd0);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h00003000;
        tick();
        redirect_i = 1'b0;
        chk("tmo_clr_fault", 64'(fault_o), 64'd0);
        tick();
        chk("tmo_resume_adr", 64'(adr_o), 64'h00003000);
        chk("tmo_resume_cyc", 64'(cyc_o), 64'd1);
`endif

        // Reset mid-cycle drops the bus asynchronously
        wait_cyc();
        #2 rst_i = 1'b1;
        #1;
        chk("async_rst_cyc", 64'(cyc_o), 64'd0);
        tick();
        rst_i = 1'b0;
        ack_now(64'h5555_5555_5555_5555);
        chk("late_ack_ignored", 64'(dir_v_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/any1_ifetch_queue.md
Name: any1_ifetch_queue

Overview:
- Instruction fetch stage directly upstream of the ANY-1 core's DECODE state.
- Fetches aligned 64-bit instruction words over the core's Wishbone-style bus and buffers them with their addresses in a small FIFO.
- Presents the head entry to decode as dir_o/ipc_o under a valid/ready handshake.
- Flushes on branch/jump redirect; in-flight bus cycles always complete cleanly.

Parameters:
- AWID, 32, address width.
- RSTPC, 32'hFFFC0100, fetch address after reset; bits [2:0] must be zero.
- DEPTH, 4, queue entries; power of two, 2..16.
- TMO_CYCLES, 255, bus timeout limit; used only with the optional feature.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- redirect_i  in  1  flush the queue and restart fetch
- redirect_pc_i  in  AWID  new fetch address; bits [2:0] ignored
- dec_rdy_i  in  1  decode accepts the head entry this cycle
- dir_v_o  out  1  head entry valid
- dir_o  out  64  head instruction word
- ipc_o  out  AWID  head instruction address
- fault_o  out  1  head entry is a bus-timeout fault (optional feature only; otherwise tied 0)
- vpa_o, cyc_o, stb_o  out  1 each  bus cycle controls
- we_o  out  1  always 0
- sel_o  out  8  byte selects
- adr_o  out  AWID  bus address
- ack_i  in  1  bus acknowledge
- dat_i  in  64  bus read data

Behaviour:
- Reset values (asynchronous):
  - vpa_o=cyc_o=stb_o=we_o=0, sel_o=0, adr_o=0.
  - dir_v_o=0, fault_o=0, count=0, rd/wr pointers=0.
  - fetch_pc=RSTPC, state=IDLE.
- IDLE:
  - If redirect_i=0 and count<DEPTH, drive vpa_o=cyc_o=stb_o=1, sel_o=8'hFF, adr_o=fetch_pc, and go to FETCH the next cycle.
  - Only one outstanding cycle is allowed.
- FETCH:
  - Hold the bus outputs stable until ack_i=1.
  - On ack_i=1: push {fetch_pc, dat_i}; fetch_pc+=8 (wraps modulo 2^AWID); deassert the bus; go to IDLE.
  - Minimum of 2 cycles per fetch (no back-to-back pipelining).
- DRAIN:
  - Hold the bus until ack_i=1, discard the data, deassert the bus, go to IDLE.
- Output handshake:
  - dir_v_o = (count!=0); dir_o and ipc_o are read combinationally from the head entry.
  - Pop occurs when dir_v_o && dec_rdy_i.
  - Push and pop in the same cycle leave count unchanged.
  - Head data must not change while dir_v_o=1 and no pop occurs.
- Full condition: no new cycle starts while count==DEPTH. The one outstanding cycle was only started when count<DEPTH, so it always has space.
- Redirect (highest priority, takes effect in the same clock edge):
  - count<=0, pointers<=0; any pop that cycle is ignored; dir_v_o=0 the next cycle.
  - fetch_pc <= {redirect_pc_i[AWID-1:3],3'b0}.
  - In FETCH with ack_i=0: go to DRAIN.
  - In FETCH with ack_i=1: discard the data, go to IDLE.
  - In IDLE: go to IDLE; the new fetch starts the following cycle.
  - In DRAIN: the new target replaces fetch_pc; remain in DRAIN.
- Reset mid-cycle: the bus drops immediately (asynchronous). Any later ack_i in IDLE is ignored.

Optional Feature:
- Macro: ANY1_IFQ_BUSTMO_EN.
- With the macro defined:
  - An 8+ bit counter runs in FETCH/DRAIN. If it reaches TMO_CYCLES without ack, the cycle is aborted (bus deasserted, back to IDLE).
  - In FETCH, a fault entry {fetch_pc, 64'd0, fault=1} is pushed and fetch_pc is not advanced; fetch then stalls until a redirect.
  - In DRAIN, a timeout is simply dropped.
- Without the macro: no counter; fault_o is constant 0; the bus waits indefinitely.

Decomposition:
- Package any1_ifq_pkg:
  - typedef ifq_state_t {IFQ_IDLE, IFQ_FETCH, IFQ_DRAIN}.
  - typedef ifq_entry_t {pc, insn, fault}.
  - constant IFQ_SEL_ALL=8'hFF.
- Sub-module any1_ifq_fifo: DEPTH-entry register FIFO with push/pop/clear and count. The top level holds the bus FSM and the redirect logic.

Test Plan:
- Reset, ack after 1 wait state, dec_rdy_i=1 -> adr_o sequence FFFC0100, FFFC0108, FFFC0110; decode sees ipc_o in the same order with the matching dat_i.
- dec_rdy_i=0, zero-wait ack -> exactly 4 pushes, then cyc_o stays 0 and count=4; set dec_rdy_i=1 for 1 cycle -> exactly one new fetch at base+0x20.
- Redirect to 0x00001004 while FETCH is pending (ack 3 cycles later) -> DRAIN, returned data discarded, next adr_o=0x00001000, dir_v_o=0 until that ack.
- Redirect and ack in the same cycle with the queue holding 2 entries -> queue empty, data dropped, next fetch at the redirect target.
- fetch_pc=FFFFFFF8, ack -> entry ipc_o=FFFFFFF8, next adr_o=00000000.
- ANY1_IFQ_BUSTMO_EN, TMO_CYCLES=4, no ack -> cyc_o drops after 4 cycles, fault_o=1 with ipc_o equal to the stalled address; no further fetch until a redirect.
